mul_div_unit: RTL
=================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all ports are listed below, clock and reset first.
REQ-002 clock  in  1  rising-edge system clock.
REQ-003 clear  in  1  synchronous active-high reset.
REQ-004 start  in  1  request operation; sampled only in IDLE or DONE.
REQ-005 op  in  1  0 = signed multiply, 1 = signed divide.
REQ-006 a  in  32  Y-register operand; multiplicand or dividend.
REQ-007 b  in  32  BusMuxOut operand; multiplier or divisor.
REQ-008 busy  out  1  high while in MUL or DIV.
REQ-009 done  out  1  one-cycle pulse when z_hi/z_lo are valid.
REQ-010 div_by_zero  out  1  divide with b = 0; valid with done.
REQ-011 z_hi  out  32  to ZHI register; product high word or remainder.
REQ-012 z_lo  out  32  to ZLO register; product low word or quotient.

Function
REQ-013 The FSM SHALL have exactly the states IDLE, MUL, DIV and DONE.
REQ-014 In IDLE or DONE, start=1 at edge k SHALL latch a, b and op, clear the 5-bit iteration counter, and enter MUL (op=0) or DIV (op=1).
REQ-015 With start=0, DONE SHALL return to IDLE on the next edge.
REQ-016 start while busy=1 SHALL be ignored, and operands SHALL NOT be re-latched.
REQ-017 MUL SHALL perform radix-2 Booth multiplication with one iteration per edge, completing 32 iterations at edges k+1..k+32, then enter DONE at edge k+32.
REQ-018 The multiply result SHALL be the full signed 64-bit product a*b, with z_hi = bits 63:32 and z_lo = bits 31:0.
REQ-019 DIV SHALL perform restoring division on operand magnitudes, one quotient bit per edge, completing at edge k+32 and entering DONE, then apply signs.
REQ-020 The divide result SHALL truncate toward zero: z_lo = quotient, z_hi = remainder, with remainder sign equal to dividend sign.
REQ-021 For 0x80000000 / 0xFFFFFFFF, the block SHALL return z_lo = 0x80000000, z_hi = 0 and div_by_zero = 0.
REQ-022 A divide with b = 0 SHALL skip iteration and enter DONE at edge k+1 with z_hi = a, z_lo = 0xFFFFFFFF and div_by_zero = 1.
REQ-023 done SHALL be 1 only in the single cycle in DONE.
REQ-024 z_hi, z_lo and div_by_zero SHALL hold their last result through IDLE until the next completion.
REQ-025 During MUL/DIV, z_hi and z_lo SHALL keep their previous result, with no intermediate values visible.
REQ-026 busy SHALL equal 1 exactly in MUL or DIV.
REQ-027 Back-to-back operation SHALL be supported: start sampled in DONE begins a new operation with no IDLE cycle.

Reset
REQ-028 clear=1 at any edge SHALL force IDLE, clear the counter, and set busy, done, div_by_zero, z_hi and z_lo to 0.
REQ-029 clear SHALL take priority over start.
REQ-030 clear mid-operation SHALL abort the operation with no done pulse.

Configuration
REQ-031 Macro DIV_EN SHALL control the divide path.
REQ-032 With DIV_EN defined, the DIV state and divider datapath SHALL be compiled in and behave per REQ-019..REQ-022.
REQ-033 Without DIV_EN, the DIV state and divider logic SHALL be absent.
REQ-034 Without DIV_EN, op=1 SHALL enter DONE at edge k+1 with z_hi = z_lo = 0 and div_by_zero = 0, while multiply is unchanged.

Verification
REQ-035 Scenario 1: a=7, b=0xFFFFFFFD, op=0, start at edge k -> busy for edges k..k+31, done after edge k+32, z_hi=0xFFFFFFFF, z_lo=0xFFFFFFEB.
REQ-036 Scenario 2: a=b=0x80000000, op=0 -> z_hi=0x40000000, z_lo=0x00000000.
REQ-037 Scenario 3 (DIV_EN): a=0xFFFFFFEF (-17), b=5, op=1 -> after edge k+32: z_lo=0xFFFFFFFD, z_hi=0xFFFFFFFE, div_by_zero=0.
REQ-038 Scenario 4 (DIV_EN): a=10, b=0, op=1 -> done after edge k+1, div_by_zero=1, z_hi=0x0000000A, z_lo=0xFFFFFFFF.
REQ-039 Scenario 5: multiply started, clear=1 at edge k+10 -> after edge k+10: busy=0 and outputs 0; no done through edge k+40; a fresh start then completes normally.
REQ-040 Scenario 6: start with a=3, b=4, then start with a=9, b=9 at edge k+5 -> second request ignored; result z_lo=12; then a new start sampled in the DONE cycle completes 32 edges later.

Source files
------------

// File: rtl/mul_div_unit.sv
// Sequential signed 32x32 multiply / divide unit.
// Ports: clock, clear (sync reset), start, op (0 mul, 1 div), a, b;
//   busy, done, div_by_zero, z_hi (high/remainder), z_lo (low/quotient).
// Macro DIV_EN compiles in the restoring divider and its DIV state.
module mul_div_unit (
   input  logic        clock,
   input  logic        clear,
   input  logic        start,
   input  logic        op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic        div_by_zero,
   output logic [31:0] z_hi,
   output logic [31:0] z_lo
);

`ifdef DIV_EN
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd3
   } state_t;
`endif

   state_t      state, nxt;
   logic [4:0]  cnt;
   logic        last;
   logic        skip;

   // acc is one bit wider so Booth add/sub of 0x80000000 cannot overflow.
   // For divide it holds the partial remainder in acc[31:0].
   logic [32:0] acc;
   logic [31:0] qr;
   logic        q_1;
   logic [31:0] m;

   logic [32:0] m_ext, bsum, b_acc;
   logic [31:0] b_qr;

   assign last = (cnt == 5'd31);

   // One radix-2 Booth step: add/sub per {q0,q-1}, then arithmetic shift.
   always_comb begin
      m_ext = {m[31], m};
      bsum  = acc;
      case ({qr[0], q_1})
         2'b01:   bsum = acc + m_ext;
         2'b10:   bsum = acc - m_ext;
         default: bsum = acc;
      endcase
      b_acc = {bsum[32], bsum[32:1]};
      b_qr  = {bsum[0], qr[31:1]};
   end

`ifdef DIV_EN
   logic        neg_q, neg_r;
   logic [32:0] d_sh, d_diff;
   logic        d_fit;
   logic [31:0] d_rem, d_quo;
   logic [31:0] abs_a, abs_b;
   logic [31:0] fin_q, fin_r, orig_a;

   assign skip = 1'b0;

   // One restoring step on magnitudes; remainder < divisor keeps d_sh
   // within 33 bits and the restored remainder within 32.
   always_comb begin
      abs_a  = a[31] ? -a : a;
      abs_b  = b[31] ? -b : b;
      d_sh   = {acc[31:0], qr[31]};
      d_diff = d_sh - {1'b0, m};
      d_fit  = ~d_diff[32];
      d_rem  = d_fit ? d_diff[31:0] : d_sh[31:0];
      d_quo  = {qr[30:0], d_fit};
      fin_q  = neg_q ? -d_quo : d_quo;
      fin_r  = neg_r ? -d_rem : d_rem;
      // qr still holds |a| when the divisor is zero
      orig_a = neg_r ? -qr : qr;
   end

   assign busy = (state == MUL) || (state == DIV);
`else
   // Divide requests pass through MUL for one cycle and return zero.
   logic opq;

   assign skip = opq;
   assign busy = (state == MUL);
`endif

   assign done = (state == DONE);

   always_ff @(posedge clock) begin
      if (clear) state <= IDLE;
      else       state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE, DONE: begin
            nxt = IDLE;
            if (start) begin
`ifdef DIV_EN
               nxt = op ? DIV : MUL;
`else
               nxt = MUL;
`endif
            end
         end
         MUL: begin
            if (last || skip) nxt = DONE;
         end
`ifdef DIV_EN
         DIV: begin
            if (last || (m == 32'd0)) nxt = DONE;
         end
`endif
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         cnt         <= 5'd0;
         acc         <= 33'd0;
         qr          <= 32'd0;
         q_1         <= 1'b0;
         m           <= 32'd0;
         z_hi        <= 32'd0;
         z_lo        <= 32'd0;
         div_by_zero <= 1'b0;
`ifdef DIV_EN
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
`else
         opq         <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE, DONE: begin
               if (start) begin
                  cnt <= 5'd0;
                  acc <= 33'd0;
                  q_1 <= 1'b0;
`ifdef DIV_EN
                  if (op) begin
                     qr    <= abs_a;
                     m     <= abs_b;
                     neg_q <= a[31] ^ b[31];
                     neg_r <= a[31];
                  end else begin
                     qr <= b;
                     m  <= a;
                  end
`else
                  opq <= op;
                  qr  <= b;
                  m   <= a;
`endif
               end
            end
            MUL: begin
               if (skip) begin
                  z_hi        <= 32'd0;
                  z_lo        <= 32'd0;
                  div_by_zero <= 1'b0;
               end else begin
                  acc <= b_acc;
                  qr  <= b_qr;
                  q_1 <= qr[0];
                  cnt <= cnt + 5'd1;
                  if (last) begin
                     z_hi        <= b_acc[31:0];
                     z_lo        <= b_qr;
                     div_by_zero <= 1'b0;
                  end
               end
            end
`ifdef DIV_EN
            DIV: begin
               if (m == 32'd0) begin
                  z_hi        <= orig_a;
                  z_lo        <= 32'hFFFF_FFFF;
                  div_by_zero <= 1'b1;
               end else begin
                  acc <= {1'b0, d_rem};
                  qr  <= d_quo;
                  cnt <= cnt + 5'd1;
                  if (last) begin
                     z_hi        <= fin_r;
                     z_lo        <= fin_q;
                     div_by_zero <= 1'b0;
                  end
               end
            end
`endif
            default: ;
         endcase
      end
   end

endmodule
